// File: rtl/host_register_bridge.sv
// host_register_bridge
//   Bridges an FT2232-style asynchronous byte FIFO to the on-chip register
//   bus. Host packets are AA, cmd, addr[2], data[4] (little-endian). Each packet
//   performs one bus write (cmd bit0=1) and then always one bus readback. The
//   bridge answers with AB followed by the readback value, little-endian.
//   While no command is in progress, bytes from the streaming multiplexer are
//   forwarded to the host. The lowest-index requesting channel wins.
//
//   Optional feature: define HOSTIF_SEND_IMMEDIATE_EN to pulse si_o low for
//   2 cycles after the last reply byte. This flushes the host FIFO.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   nrxf_i, ntxe_i        host FIFO status (active low)
//   nrd_o, wr_o, si_o     host FIFO strobes
//   d_io[7:0]             host FIFO data bus (tristate)
//   omux_data_i/req_i     streaming channel data / per-channel request
//   omux_sel_o            selected streaming channel
//   reg_addr_o[15:0]      register bus address
//   reg_data_io[31:0]     register bus data (tristate)
//   reg_wr_o              register write strobe
module host_register_bridge #(
    parameter int N_CHAN   = 1,
    parameter int RD_PULSE = 2,
    parameter int WR_PULSE = 2
) (
    input  logic                                           clk_i,
    input  logic                                           reset_i,
    input  logic                                           nrxf_i,
    input  logic                                           ntxe_i,
    output logic                                           nrd_o,
    output logic                                           wr_o,
    output logic                                           si_o,
    inout  wire  [7:0]                                     d_io,
    input  logic [7:0]                                     omux_data_i,
    input  logic [N_CHAN-1:0]                              omux_req_i,
    output logic [((N_CHAN > 1) ? $clog2(N_CHAN) : 1)-1:0] omux_sel_o,
    output logic [15:0]                                    reg_addr_o,
    inout  wire  [31:0]                                    reg_data_io,
    output logic                                           reg_wr_o
);

    localparam int SEL_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    typedef enum logic [4:0] {
        P_IDLE, P_CMD, P_ADDR0, P_ADDR1, P_DATA0, P_DATA1, P_DATA2, P_DATA3,
        P_BUS_WR, P_BUS_REL, P_BUS_SAMPLE,
        P_REPLY0, P_REPLY1, P_REPLY2, P_REPLY3, P_REPLY4
    } p_state_t;

    typedef enum logic [3:0] {
        E_IDLE, E_RD, E_RD_GAP, E_STREAM_SEL, E_WR_WAIT,
        E_WR_SETUP, E_WR_STROBE, E_WR_HOLD, E_SI_WAIT, E_SI
    } e_state_t;

    p_state_t         p_state_q, p_state_d;
    e_state_t         eng_q, eng_d;
    logic [7:0]       eng_cnt_q, eng_cnt_d;
    logic             bus_cnt_q, bus_cnt_d;
    logic [15:0]      reg_addr_q, reg_addr_d;
    logic [SEL_W-1:0] omux_sel_q, omux_sel_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             is_wr_q, is_wr_d;
    logic [7:0]       addr_lo_q, addr_lo_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      rdata_q, rdata_d;
`ifdef HOSTIF_SEND_IMMEDIATE_EN
    logic             tx_last_q, tx_last_d;
`endif

    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             tx_done;
    logic             tx_req;
    logic             p_accept;
    logic [7:0]       reply_byte;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;

    // The last low cycle of nrd_o is the one where the host byte is taken.
    assign rx_valid = (eng_q == E_RD) && (eng_cnt_q == 8'(RD_PULSE - 1));
    assign rx_byte  = d_io;
    assign p_accept = p_state_q inside {P_IDLE, P_CMD, P_ADDR0, P_ADDR1,
                                        P_DATA0, P_DATA1, P_DATA2, P_DATA3};
    assign tx_req   = p_state_q inside {P_REPLY0, P_REPLY1, P_REPLY2,
                                        P_REPLY3, P_REPLY4};

    // Outputs decode directly from registered state.
    assign nrd_o       = (eng_q != E_RD);
    assign wr_o        = (eng_q == E_WR_STROBE);
    assign d_io        = (eng_q inside {E_WR_SETUP, E_WR_STROBE, E_WR_HOLD}) ? tx_byte_q : 8'hzz;
    assign reg_wr_o    = (p_state_q == P_BUS_WR);
    assign reg_data_io = (p_state_q == P_BUS_WR) ? data_q : 32'hzzzz_zzzz;
    assign reg_addr_o  = reg_addr_q;
    assign omux_sel_o  = omux_sel_q;
`ifdef HOSTIF_SEND_IMMEDIATE_EN
    assign si_o        = (eng_q != E_SI);
`else
    assign si_o        = 1'b1;
`endif

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (omux_req_i[i]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        case (p_state_q)
            P_REPLY1: reply_byte = rdata_q[7:0];
            P_REPLY2: reply_byte = rdata_q[15:8];
            P_REPLY3: reply_byte = rdata_q[23:16];
            P_REPLY4: reply_byte = rdata_q[31:24];
            default:  reply_byte = 8'hAB;
        endcase
    end

    // Host FIFO engine: a reply byte has priority over reads. A pending host
    // byte has priority over streaming.
    always_comb begin
        eng_d      = eng_q;
        eng_cnt_d  = eng_cnt_q;
        tx_byte_d  = tx_byte_q;
        omux_sel_d = omux_sel_q;
        tx_done    = 1'b0;
`ifdef HOSTIF_SEND_IMMEDIATE_EN
        tx_last_d  = tx_last_q;
`endif
        case (eng_q)
            E_IDLE: begin
                if (tx_req) begin
                    tx_byte_d = reply_byte;
                    eng_d     = E_WR_WAIT;
`ifdef HOSTIF_SEND_IMMEDIATE_EN
                    tx_last_d = (p_state_q == P_REPLY4);
`endif
                end else if (p_accept && !nrxf_i) begin
                    eng_d     = E_RD;
                    eng_cnt_d = '0;
                end else if (p_state_q == P_IDLE && win_found) begin
                    eng_d      = E_STREAM_SEL;
                    omux_sel_d = win_idx;
                end
            end
            E_RD: begin
                eng_cnt_d = eng_cnt_q + 8'd1;
                if (rx_valid) begin
                    eng_d     = E_RD_GAP;
                    eng_cnt_d = '0;
                end
            end
            E_RD_GAP: begin
                eng_cnt_d = eng_cnt_q + 8'd1;
                if (eng_cnt_q == 8'd1) eng_d = E_IDLE;
            end
            E_STREAM_SEL: begin
                // Mux output has had one cycle to follow omux_sel_o.
                tx_byte_d = omux_data_i;
                eng_d     = E_WR_WAIT;
`ifdef HOSTIF_SEND_IMMEDIATE_EN
                tx_last_d = 1'b0;
`endif
            end
            E_WR_WAIT:  if (!ntxe_i) eng_d = E_WR_SETUP;
            E_WR_SETUP: begin
                eng_d     = E_WR_STROBE;
                eng_cnt_d = '0;
            end
            E_WR_STROBE: begin
                eng_cnt_d = eng_cnt_q + 8'd1;
                if (eng_cnt_q == 8'(WR_PULSE - 1)) eng_d = E_WR_HOLD;
            end
            E_WR_HOLD: begin
                tx_done = 1'b1;
                eng_d   = E_IDLE;
`ifdef HOSTIF_SEND_IMMEDIATE_EN
                if (tx_last_q) eng_d = E_SI_WAIT;
`endif
            end
`ifdef HOSTIF_SEND_IMMEDIATE_EN
            E_SI_WAIT: begin
                if (!ntxe_i) begin
                    eng_d     = E_SI;
                    eng_cnt_d = '0;
                end
            end
            E_SI: begin
                eng_cnt_d = eng_cnt_q + 8'd1;
                if (eng_cnt_q == 8'd1) eng_d = E_IDLE;
            end
`endif
            default: eng_d = E_IDLE;
        endcase
    end

    // Packet parser and bus sequencer.
    always_comb begin
        p_state_d  = p_state_q;
        bus_cnt_d  = bus_cnt_q;
        reg_addr_d = reg_addr_q;
        is_wr_d    = is_wr_q;
        addr_lo_d  = addr_lo_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        case (p_state_q)
            P_IDLE:  if (rx_valid && rx_byte == 8'hAA) p_state_d = P_CMD;
            P_CMD: if (rx_valid) begin
                is_wr_d   = rx_byte[0];
                p_state_d = P_ADDR0;
            end
            P_ADDR0: if (rx_valid) begin
                addr_lo_d = rx_byte;
                p_state_d = P_ADDR1;
            end
            P_ADDR1: if (rx_valid) begin
                reg_addr_d = {rx_byte, addr_lo_q};
                p_state_d  = P_DATA0;
            end
            P_DATA0: if (rx_valid) begin
                data_d[7:0] = rx_byte;
                p_state_d   = P_DATA1;
            end
            P_DATA1: if (rx_valid) begin
                data_d[15:8] = rx_byte;
                p_state_d    = P_DATA2;
            end
            P_DATA2: if (rx_valid) begin
                data_d[23:16] = rx_byte;
                p_state_d     = P_DATA3;
            end
            P_DATA3: if (rx_valid) begin
                data_d[31:24] = rx_byte;
                bus_cnt_d     = 1'b0;
                p_state_d     = is_wr_q ? P_BUS_WR : P_BUS_REL;
            end
            P_BUS_WR: begin
                bus_cnt_d = 1'b0;
                p_state_d = P_BUS_REL;
            end
            // Two released cycles let the addressed register drive the bus.
            P_BUS_REL: begin
                bus_cnt_d = 1'b1;
                if (bus_cnt_q) p_state_d = P_BUS_SAMPLE;
            end
            P_BUS_SAMPLE: begin
                rdata_d   = reg_data_io;
                p_state_d = P_REPLY0;
            end
            P_REPLY0: if (tx_done) p_state_d = P_REPLY1;
            P_REPLY1: if (tx_done) p_state_d = P_REPLY2;
            P_REPLY2: if (tx_done) p_state_d = P_REPLY3;
            P_REPLY3: if (tx_done) p_state_d = P_REPLY4;
            P_REPLY4: if (tx_done) p_state_d = P_IDLE;
            default:  p_state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            p_state_q  <= P_IDLE;
            eng_q      <= E_IDLE;
            eng_cnt_q  <= '0;
            bus_cnt_q  <= 1'b0;
            reg_addr_q <= '0;
            omux_sel_q <= '0;
        end else begin
            p_state_q  <= p_state_d;
            eng_q      <= eng_d;
            eng_cnt_q  <= eng_cnt_d;
            bus_cnt_q  <= bus_cnt_d;
            reg_addr_q <= reg_addr_d;
            omux_sel_q <= omux_sel_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tx_byte_q <= tx_byte_d;
        is_wr_q   <= is_wr_d;
        addr_lo_q <= addr_lo_d;
        data_q    <= data_d;
        rdata_q   <= rdata_d;
`ifdef HOSTIF_SEND_IMMEDIATE_EN
        tx_last_q <= tx_last_d;
`endif
    end

endmodule

// File: tb/tb_host_register_bridge.sv
module tb_host_register_bridge;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        nrxf_i;
    logic        ntxe_i;
    logic        nrd_o;
    logic        wr_o;
    logic        si_o;
    wire  [7:0]  d_io;
    logic [7:0]  omux_data_i;
    logic [1:0]  omux_req_i;
    logic [0:0]  omux_sel_o;
    logic [15:0] reg_addr_o;
    wire  [31:0] reg_data_io;
    logic        reg_wr_o;

    host_register_bridge #(.N_CHAN(2), .RD_PULSE(2), .WR_PULSE(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .nrxf_i(nrxf_i), .ntxe_i(ntxe_i),
        .nrd_o(nrd_o), .wr_o(wr_o), .si_o(si_o), .d_io(d_io),
        .omux_data_i(omux_data_i), .omux_req_i(omux_req_i), .omux_sel_o(omux_sel_o),
        .reg_addr_o(reg_addr_o), .reg_data_io(reg_data_io), .reg_wr_o(reg_wr_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Peripherals: plain at 1, read-only at 2, counter at 3, pull-down elsewhere.
    logic [31:0] plain_q;
    logic [31:0] cnt_q;
    wire mapped = (reg_addr_o == 16'h0001) || (reg_addr_o == 16'h0002) || (reg_addr_o == 16'h0003);
    assign reg_data_io = (!reg_wr_o && reg_addr_o == 16'h0001) ? plain_q : 32'hzzzz_zzzz;
    assign reg_data_io = (!reg_wr_o && reg_addr_o == 16'h0002) ? 32'hfeedbeef : 32'hzzzz_zzzz;
    assign reg_data_io = (!reg_wr_o && reg_addr_o == 16'h0003) ? cnt_q : 32'hzzzz_zzzz;
    assign reg_data_io = (!reg_wr_o && !mapped) ? 32'h0 : 32'hzzzz_zzzz;

    always @(posedge clk_i) begin
        if (reset_i) begin
            plain_q <= 32'h0;
            cnt_q   <= 32'h0;
        end else begin
            if (reg_wr_o && reg_addr_o == 16'h0001) plain_q <= reg_data_io;
            if (reg_wr_o && reg_addr_o == 16'h0003) cnt_q <= 32'h0;
            else cnt_q <= cnt_q + 32'd1;
        end
    end

    // Stream mux: channel 0 = 0x5A, channel 1 = 0xC3.
    assign omux_data_i = omux_sel_o[0] ? 8'hC3 : 8'h5A;

    // Host FIFO model: drives d_io while nrd_o is low.
    logic [7:0] host_q[$];
    logic [7:0] host_byte = 8'h00;
    assign d_io = (!nrd_o) ? host_byte : 8'hzz;

    initial begin
        logic prev_nrd;
        prev_nrd = 1'b1;
        nrxf_i   = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!prev_nrd && nrd_o && host_q.size() > 0) void'(host_q.pop_front());
            if (host_q.size() > 0) host_byte = host_q[0];
            nrxf_i   = (host_q.size() == 0);
            prev_nrd = nrd_o;
        end
    end

    // Scoreboard monitor: a byte is taken by the host on the falling edge of wr_o.
    typedef struct packed {
        logic [7:0] val;
        logic       care;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] last_word = 32'h0;
    int          proto_err = 0;
    int          wr_run = 0;
    int          wr_pulses = 0;

    initial begin
        logic prev_wr;
        exp_t e;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!nrd_o && wr_o) proto_err++;
            if (reg_wr_o) wr_run++;
            else if (wr_run != 0) begin
                chk("reg_wr_width", wr_run, 1);
                wr_pulses++;
                wr_run = 0;
            end
            if (prev_wr && !wr_o) begin
                last_word = {d_io, last_word[31:8]};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_host_byte actual=%h required=none", d_io);
                end else begin
                    e = exp_q.pop_front();
                    if (e.care) chk("host_byte", {24'h0, d_io}, {24'h0, e.val});
                end
            end
            prev_wr = wr_o;
        end
    end

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || host_q.size() != 0) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=%0d_bytes_outstanding required=0", name, exp_q.size());
            exp_q.delete();
            host_q.delete();
        end
        repeat (10) @(negedge clk_i);
    endtask

    task automatic send_cmd(string name, logic [7:0] cmd, logic [15:0] addr,
                            logic [31:0] data, logic care, logic [31:0] rv);
        exp_q.push_back('{8'hAB, 1'b1});
        exp_q.push_back('{rv[7:0], care});
        exp_q.push_back('{rv[15:8], care});
        exp_q.push_back('{rv[23:16], care});
        exp_q.push_back('{rv[31:24], care});
        host_q.push_back(8'hAA);
        host_q.push_back(cmd);
        host_q.push_back(addr[7:0]);
        host_q.push_back(addr[15:8]);
        host_q.push_back(data[7:0]);
        host_q.push_back(data[15:8]);
        host_q.push_back(data[23:16]);
        host_q.push_back(data[31:24]);
        wait_idle(name);
    endtask

    task automatic stream(string name, logic [1:0] req, logic [7:0] b);
        int n;
        exp_q.push_back('{b, 1'b1});
        omux_req_i = req;
        n = 0;
        while (!wr_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        omux_req_i = 2'b00;
        wait_idle(name);
    endtask

    initial begin
        logic [31:0] c1;
        logic [31:0] c2;
        reset_i    = 1'b1;
        ntxe_i     = 1'b0;
        omux_req_i = 2'b00;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_nrd", {31'h0, nrd_o}, 1);
        chk("rst_wr", {31'h0, wr_o}, 0);
        chk("rst_si", {31'h0, si_o}, 1);
        chk("rst_reg_wr", {31'h0, reg_wr_o}, 0);
        chk("rst_reg_addr", {16'h0, reg_addr_o}, 0);
        chk("rst_omux_sel", {31'h0, omux_sel_o}, 0);

        host_q.push_back(8'h55);
        host_q.push_back(8'h55);
        send_cmd("wr_deadbeef", 8'h01, 16'h0001, 32'hdeadbeef, 1'b1, 32'hdeadbeef);
        send_cmd("wr_ffff", 8'hA5, 16'h0001, 32'h0000ffff, 1'b1, 32'h0000ffff);
        chk("plain_reg_value", plain_q, 32'h0000ffff);
        chk("reg_addr_held", {16'h0, reg_addr_o}, 32'h0001);
        send_cmd("rd_plain", 8'h02, 16'h0001, 32'h12345678, 1'b1, 32'h0000ffff);
        send_cmd("wr_readonly", 8'h01, 16'h0002, 32'h0000ffff, 1'b1, 32'hfeedbeef);

        send_cmd("cnt_rd1", 8'h00, 16'h0003, 32'h0, 1'b0, 32'h0);
        c1 = last_word;
        chk("cnt_rd1_nonzero", {31'h0, c1 != 0}, 1);
        send_cmd("cnt_rd2", 8'h00, 16'h0003, 32'h0, 1'b0, 32'h0);
        c2 = last_word;
        chk("cnt_rd2_larger", {31'h0, c2 > c1}, 1);
        send_cmd("cnt_wr", 8'h01, 16'h0003, 32'h0000ffff, 1'b0, 32'h0);
        chk("cnt_wr_cleared", {31'h0, last_word <= 32'd4}, 1);

        host_q.push_back(8'h55);
        send_cmd("wr_unmapped", 8'h01, 16'h0010, 32'hcafef00d, 1'b1, 32'h0);

        stream("stream_ch1", 2'b10, 8'hC3);
        stream("stream_both", 2'b11, 8'h5A);
        stream("stream_ch0", 2'b01, 8'h5A);
        chk("stream_sel_after", {31'h0, omux_sel_o}, 0);

        chk("nrd_wr_overlap", proto_err, 0);
        chk("reg_wr_pulse_count", wr_pulses, 5);
        chk("si_idle_high", {31'h0, si_o}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
